// File: rtl/mem_burst_if.sv
// Burst request/ack bus between an initiator (master) and the memory responder (slave).
`timescale 1ns/1ps
interface mem_burst_if;
    logic        req;
    logic        rw;
    logic [47:0] addr;
    logic [31:0] len;
    logic        ack;
    logic        err;
    logic        busy;
    logic        wr_valid;
    logic [63:0] wr_data;
    logic        wr_ready;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        rd_ready;

    modport master (
        output req, rw, addr, len, wr_valid, wr_data, rd_ready,
        input  ack, err, busy, wr_ready, rd_valid, rd_data
    );

    modport slave (
        input  req, rw, addr, len, wr_valid, wr_data, rd_ready,
        output ack, err, busy, wr_ready, rd_valid, rd_data
    );
endinterface

// File: rtl/mem_burst_responder.sv
// Memory-side burst responder: validates one request, streams 64-bit words into or out
// of a single-port synchronous SRAM model, and closes each burst with a one-cycle ack.
`timescale 1ns/1ps
module mem_burst_responder #(
    parameter int DEPTH   = 8192,
    parameter int IDX_W   = 13,
    parameter int MAX_LEN = 8192
) (
    input logic        clk,
    input logic        rst,
    mem_burst_if.slave bus
);

    localparam int CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_ACK
    } state_t;

    state_t r_state;
    state_t w_next;

    // Burst context captured in IDLE
    logic [IDX_W-1:0] r_base;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_cnt;     // words written, or reads issued
    logic [CNT_W-1:0] r_beats;   // read beats accepted by the initiator
    logic             r_err;

    // Read path: SRAM output stage plus a 2-entry skid buffer
    logic [63:0]      r_mem [DEPTH];
    logic [63:0]      r_sram_q_p1;
    logic             r_vld_p1;
    logic [63:0]      r_buf [2];
    logic             r_head;
    logic [1:0]       r_bcnt;

    logic [IDX_W-1:0] w_base;
    logic [32:0]      w_end;
    logic             w_bad;
    logic [IDX_W-1:0] w_mem_idx;
    logic             w_wr_fire;
    logic             w_rd_vld;
    logic             w_rd_fire;
    logic             w_issue;
    logic             w_push;
    logic             w_pop;
    logic             w_tail;
    logic             w_unused_addr;

    // Capture-time validation; the end index is formed in 33 bits so it cannot wrap.
    assign w_base        = bus.addr[IDX_W+2:3];
    assign w_end         = {{(33-IDX_W){1'b0}}, w_base} + {1'b0, bus.len};
    assign w_bad         = (bus.addr[2:0] != 3'b000) || (bus.len > 32'(MAX_LEN)) ||
                           (w_end > 33'(DEPTH));
    assign w_unused_addr = ^bus.addr[47:IDX_W+3];

    // Legal bursts stay below DEPTH, so the IDX_W-bit sum never needs a carry.
    assign w_mem_idx = r_base + r_cnt[IDX_W-1:0];

    assign w_wr_fire = (r_state == S_WR) && bus.wr_valid;

    // Head of the buffer wins; otherwise the word just out of the SRAM is presented directly.
    assign w_rd_vld  = (r_bcnt != 2'd0) || r_vld_p1;
    assign w_rd_fire = w_rd_vld && bus.rd_ready;
    assign w_issue   = (r_state == S_RD) && (r_cnt < r_len) &&
                       ((r_bcnt + {1'b0, r_vld_p1}) < 2'd2);
    assign w_push    = r_vld_p1 && !((r_bcnt == 2'd0) && bus.rd_ready);
    assign w_pop     = (r_bcnt != 2'd0) && bus.rd_ready;
    assign w_tail    = r_head + r_bcnt[0];

    assign bus.ack      = (r_state == S_ACK);
    assign bus.err      = (r_state == S_ACK) && r_err;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.wr_ready = (r_state == S_WR);
    assign bus.rd_valid = w_rd_vld;
    assign bus.rd_data  = (r_bcnt != 2'd0) ? r_buf[r_head] :
                          (r_vld_p1 ? r_sram_q_p1 : 64'd0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.req) begin
                    if (w_bad || (bus.len == 32'd0)) begin
                        w_next = S_ACK;
                    end else if (bus.rw) begin
                        w_next = S_WR;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_WR: begin
                if (w_wr_fire && ((r_cnt + CNT_W'(1)) == r_len)) begin
                    w_next = S_ACK;
                end
            end
            S_RD: begin
                if (w_rd_fire && ((r_beats + CNT_W'(1)) == r_len)) begin
                    w_next = S_ACK;
                end
            end
            S_ACK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Burst counters and read-buffer bookkeeping
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_base   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_beats  <= '0;
            r_err    <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_head   <= 1'b0;
            r_bcnt   <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_base  <= w_base;
                        r_len   <= bus.len[CNT_W-1:0];
                        r_cnt   <= '0;
                        r_beats <= '0;
                        r_err   <= w_bad;
                    end
                end
                S_WR: begin
                    if (w_wr_fire) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RD: begin
                    if (w_issue) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                    if (w_rd_fire) begin
                        r_beats <= r_beats + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
            r_vld_p1 <= w_issue;
            r_bcnt   <= r_bcnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) begin
                r_head <= ~r_head;
            end
        end
    end

    // SRAM array, its registered read port, and buffer storage (contents are never reset)
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_mem[w_mem_idx] <= bus.wr_data;
        end
        if (w_issue) begin
            r_sram_q_p1 <= r_mem[w_mem_idx];
        end
        if (w_push) begin
            r_buf[w_tail] <= r_sram_q_p1;
        end
    end

endmodule

// File: tb/tb_mem_burst_responder.sv
// Bench for mem_burst_responder: directed vector table, hand-written reset/backpressure
// sequences, and randomized bursts checked against a word-array memory model.
`timescale 1ns/1ps
module tb_mem_burst_responder;

    localparam int DEPTH   = 8192;
    localparam int IDX_W   = 13;
    localparam int MAX_LEN = 8192;

    logic clk;
    logic rst;
    mem_burst_if bus();

    mem_burst_responder #(
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] model [DEPTH];

    typedef struct {
        logic        rw;
        logic [47:0] addr;
        logic [31:0] len;
        logic [63:0] pat;
        int          rd_mode;
        logic        exp_err;
        int          exp_ack;
    } vec_t;

    vec_t tbl [14];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    function automatic logic model_err(input logic [47:0] a, input logic [31:0] l);
        longint base;
        base = (longint'(a) / 8) % DEPTH;
        return ((longint'(a) % 8) != 0) || (longint'(l) > MAX_LEN) ||
               (base + longint'(l) > DEPTH);
    endfunction

    // One complete burst from request to the idle cycle after ack.
    // rd_mode: 0 ready always, 1 random, 2 pattern 1,0,0 from the first possible beat.
    // wr_mode: 0 valid always, 1 random. exp_ack < 0 skips the absolute latency check.
    task automatic run_burst(input logic rw_i, input logic [47:0] a, input logic [31:0] l,
                             input logic [63:0] pat, input int rd_mode, input int wr_mode,
                             input logic exp_err, input int exp_ack);
        int          cyc;
        int          rbeats;
        int          wbeats;
        int          last;
        int          first;
        int          budget;
        int          base;
        logic        acked;
        logic        prev_stall;
        logic [63:0] prev_d;
        logic        rdy;
        logic        v;
        logic [63:0] d;
        cyc = 0; rbeats = 0; wbeats = 0; last = -1; first = -1;
        acked = 1'b0; prev_stall = 1'b0; prev_d = '0;
        base = int'((longint'(a) / 8) % DEPTH);
        budget = 4 * int'(l) + 40;
        if (budget > 4 * DEPTH + 40) budget = 4 * DEPTH + 40;
        bus.req = 1'b1; bus.rw = rw_i; bus.addr = a; bus.len = l;
        bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
        while (!acked && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            check("busy", bus.busy, 1'b1);
            if (bus.ack) begin
                acked = 1'b1;
                check("err", bus.err, exp_err);
                if (exp_ack >= 0) check("ack_cycle", 64'(cyc), 64'(exp_ack));
                check("rd_beats", 64'(rbeats), 64'((!rw_i && !exp_err) ? l : 0));
                check("wr_beats", 64'(wbeats), 64'((rw_i && !exp_err) ? l : 0));
                if (!exp_err && l != 0) begin
                    check("ack_after_last", 64'(cyc), 64'(last + 1));
                    check("first_beat_cycle", 64'(first), 64'(rw_i ? 1 : 2));
                end
                bus.req = 1'b0; bus.wr_valid = 1'b0; bus.rd_ready = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("rd_hold_valid", bus.rd_valid, 1'b1);
                    check("rd_hold_data", bus.rd_data, prev_d);
                end
                case (rd_mode)
                    0:       rdy = 1'b1;
                    1:       rdy = 1'($urandom % 2);
                    default: rdy = ((cyc % 3) == 2);
                endcase
                bus.rd_ready = rdy;
                if (bus.rd_valid && first < 0) first = cyc;
                if (bus.rd_valid && rdy) begin
                    check("rd_data", bus.rd_data, model[(base + rbeats) % DEPTH]);
                    rbeats++;
                    last = cyc;
                end
                prev_stall = bus.rd_valid && !rdy;
                prev_d = bus.rd_data;
                v = (wr_mode == 0) ? 1'b1 : 1'(($urandom % 4) != 0);
                d = (pat != 0) ? pat + 64'(wbeats) : {$urandom, $urandom};
                bus.wr_valid = v;
                bus.wr_data = d;
                if (bus.wr_ready && first < 0) first = cyc;
                if (v && bus.wr_ready) begin
                    model[(base + wbeats) % DEPTH] = d;
                    wbeats++;
                    last = cyc;
                end
            end
        end
        check("ack_seen", acked, 1'b1);
        @(posedge clk); #1;
        check("idle_ack", bus.ack, 1'b0);
        check("idle_busy", bus.busy, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] a;
        logic [31:0] l;
        logic        rw_r;
        int          idx;
        logic [63:0] d;

        //            rw    addr                len           pat     rdm err  ack
        tbl[0]  = '{1'b1, 48'h0,              32'(DEPTH),   64'h0,  0, 1'b0, DEPTH + 1};
        tbl[1]  = '{1'b0, 48'h0,              32'(DEPTH),   64'h0,  0, 1'b0, DEPTH + 2};
        tbl[2]  = '{1'b1, 48'h100,            32'd4,        64'hA0, 0, 1'b0, 5};
        tbl[3]  = '{1'b0, 48'h100,            32'd4,        64'h0,  0, 1'b0, 6};
        tbl[4]  = '{1'b0, 48'h100,            32'd8,        64'h0,  2, 1'b0, -1};
        tbl[5]  = '{1'b0, 48'h104,            32'd4,        64'h0,  0, 1'b1, 1};
        tbl[6]  = '{1'b1, 48'h104,            32'd4,        64'h0,  0, 1'b1, 1};
        tbl[7]  = '{1'b0, 48'((DEPTH-2)*8),   32'd4,        64'h0,  0, 1'b1, 1};
        tbl[8]  = '{1'b1, 48'((DEPTH-2)*8),   32'd4,        64'h0,  0, 1'b1, 1};
        tbl[9]  = '{1'b1, 48'h0,              32'(MAX_LEN+1), 64'h0, 0, 1'b1, 1};
        tbl[10] = '{1'b0, 48'h0,              32'd0,        64'h0,  0, 1'b0, 1};
        tbl[11] = '{1'b1, 48'h40,             32'd0,        64'h0,  0, 1'b0, 1};
        tbl[12] = '{1'b0, 48'((DEPTH-4)*8),   32'd4,        64'h0,  0, 1'b0, 6};
        tbl[13] = '{1'b1, 48'((DEPTH-1)*8),   32'd1,        64'h77, 0, 1'b0, 2};

        rst = 1'b1;
        bus.req = 1'b0; bus.rw = 1'b0; bus.addr = '0; bus.len = '0;
        bus.wr_valid = 1'b0; bus.wr_data = '0; bus.rd_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", bus.ack, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_wr_ready", bus.wr_ready, 1'b0);
        check("rst_rd_valid", bus.rd_valid, 1'b0);
        check("rst_rd_data", bus.rd_data, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_no_req", bus.busy, 1'b0);

        // Directed table
        for (int i = 0; i < 14; i++) begin
            run_burst(tbl[i].rw, tbl[i].addr, tbl[i].len, tbl[i].pat, tbl[i].rd_mode, 0,
                      tbl[i].exp_err, tbl[i].exp_ack);
        end

        // Randomized bursts against the model
        for (int n = 0; n < 40; n++) begin
            if ($urandom % 5 == 0) idx = $urandom_range(DEPTH - 1, DEPTH - 40);
            else                   idx = $urandom_range(DEPTH - 1, 0);
            a = 48'(longint'(idx) * 8 + (($urandom % 8 == 0) ? 4 : 0));
            l = 32'($urandom_range(40, 0));
            rw_r = 1'($urandom % 2);
            run_burst(rw_r, a, l, 64'h0, 1, 1, model_err(a, l), -1);
        end

        // Reset during the third beat of an 8-beat write at word 0
        bus.req = 1'b1; bus.rw = 1'b1; bus.addr = 48'h0; bus.len = 32'd8;
        bus.wr_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            check("rstwr_ready", bus.wr_ready, 1'b1);
            d = 64'h5000 + 64'(c - 1);
            bus.wr_valid = 1'b1;
            bus.wr_data = d;
            if (c < 3) model[c - 1] = d;
            else       rst = 1'b1;
        end
        #1;
        check("abort_ack", bus.ack, 1'b0);
        check("abort_err", bus.err, 1'b0);
        check("abort_busy", bus.busy, 1'b0);
        check("abort_wr_ready", bus.wr_ready, 1'b0);
        check("abort_rd_valid", bus.rd_valid, 1'b0);
        check("abort_rd_data", bus.rd_data, 64'd0);
        bus.req = 1'b0; bus.wr_valid = 1'b0;
        @(posedge clk); #1;
        check("abort_hold_ack", bus.ack, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_idle", bus.busy, 1'b0);
        run_burst(1'b0, 48'h0, 32'd4, 64'h0, 0, 0, 1'b0, 6);

        // Full read-back: error bursts and the aborted write must not have disturbed anything
        run_burst(1'b0, 48'h0, 32'(DEPTH), 64'h0, 1, 0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_burst_responder.md
# mem_burst_responder

Memory-side responder for the NTT memory arbiter: accepts one granted burst request (read or write, byte address, word length), moves 64-bit words between the initiator and an internal single-port SRAM model, and closes each burst with a one-cycle `ack`. It terminates the request/ack protocol the arbiter drives downstream, and stands in for external memory in Verilator co-simulation.

## Interface
- `DEPTH`, 8192, number of 64-bit words in the backing store (2*N for N=4096).
- `IDX_W`, 13, word-index width; must equal clog2(DEPTH).
- `MAX_LEN`, 8192, largest legal burst length in words.
- `clk`  in  1  single clock; all logic rises on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  1  request level; held by the initiator until `ack`.
- `rw`  in  1  1 = write to memory, 0 = read from memory; sampled with `req`.
- `addr`  in  48  byte address; must be 8-byte aligned.
- `len`  in  32  burst length in 64-bit words.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `ack`; 1 = request rejected, no memory access.
- `busy`  out  1  high from request capture until the `ack` cycle inclusive.
- `wr_valid`  in  1  write beat valid.
- `wr_data`  in  64  write beat data.
- `wr_ready`  out  1  responder accepts a write beat.
- `rd_valid`  out  1  read beat valid.
- `rd_data`  out  64  read beat data.
- `rd_ready`  in  1  initiator accepts a read beat.

## Operation
- States: IDLE, WR, RD, ACK.
- IDLE: on posedge with `req`=1, latch `rw`, base index = `addr[IDX_W+2:3]`, `len`; beat count := 0.
- Validity check at capture: error if `addr[2:0]`!=0, `len`>MAX_LEN, or base+`len` > DEPTH (compute in 33+ bits, no wrap). Error -> ACK with `err`=1; no beats, no memory writes.
- `len`=0 with valid address -> ACK with `err`=0, no beats.
- Otherwise `rw`=1 -> WR, `rw`=0 -> RD.
- WR: `wr_ready`=1 while count<len. Each `wr_valid&&wr_ready` cycle writes `mem[base+count]` and increments count. After the beat where count reaches len -> ACK.
- RD: issue reads in order base..base+len-1 into a 1-cycle synchronous SRAM. A 2-entry output buffer absorbs backpressure. Issue is allowed only when buffer occupancy plus in-flight reads < 2. `rd_data` is held stable while `rd_valid`&&!`rd_ready`. After the last beat is accepted -> ACK.
- ACK: `ack`=1 and `err` valid for exactly one cycle, then IDLE. `req` is ignored in ACK.
- The initiator deasserts `req` on the edge where it samples `ack`=1. A `req` still high in IDLE afterwards starts a new burst.
- Memory contents are not reset and persist across bursts.
- Index arithmetic: base+count in IDX_W+1 bits. Legal requests never wrap.

## Timing
- Reset values: `ack`=0, `err`=0, `busy`=0, `wr_ready`=0, `rd_valid`=0, `rd_data`=0, state IDLE, output buffer empty.
- Reset mid-burst: immediate abort, no `ack`. Writes already accepted remain in memory.
- Capture edge T0 (`req` sampled). Error and `len`=0 cases give `ack` in cycle T0+1.
- Write: `wr_ready` high from T0+1. With `wr_valid` held high, the last beat is in cycle T0+len and `ack` is in T0+len+1.
- Read: first `rd_valid` in T0+2. With `rd_ready` held high, one beat per cycle, the last beat is in T0+len+1 and `ack` is in T0+len+2.
- `busy` is high from T0+1 through the `ack` cycle.
- A write beat presented while `wr_ready`=0 is not consumed.
- `wr_valid` gaps and `rd_ready` stalls only extend the burst; no beat is dropped or duplicated.

## Test plan
- Write burst, addr=0x100, len=4, data 0xA0..0xA3, `wr_valid` held high -> `wr_ready` for 4 cycles, `ack` at T0+5, `err`=0; mem[32..35] = 0xA0..0xA3.
- Read back the same range with `rd_ready` held high -> `rd_valid` in T0+2..T0+5 with 0xA0..0xA3 in order, `ack` at T0+6.
- Read len=8 with `rd_ready` toggling 1,0,0,1,... -> exactly 8 beats, in order, `rd_data` stable during stalls, `ack` one cycle after the 8th accepted beat.
- Error cases: addr=0x104 (misaligned); addr=(DEPTH-2)*8 with len=4 (overrun); len=MAX_LEN+1 -> each gives `ack`+`err`=1 at T0+1 with no beats and memory unchanged. len=0 -> `ack`, `err`=0 at T0+1.
- Boundary: write len=DEPTH at addr=0, then read back -> full-memory round trip matches, no wrap.
- Assert `rst` at the third beat of an 8-beat write -> all outputs 0 immediately, no `ack`. A fresh burst after reset completes normally, and words 0..1 hold the pre-reset data.
